// File: rtl/param_register.sv
// param_register: parametrised general-purpose datapath register.
// Supports byte-lane-enabled parallel load, one-bit shift/rotate modes with
// serial in/out, synchronous clear to RESET_VAL and an asynchronous
// active-low reset. zero is a combinational flag derived from q.
module param_register #(
    parameter int               WIDTH     = 32,
    parameter int               LANE      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [2:0]              mode,
    input  logic [WIDTH/LANE-1:0]   be,
    input  logic [WIDTH-1:0]        d,
    input  logic                    sin,
    output logic [WIDTH-1:0]        q,
    output logic                    sout,
    output logic                    zero
);

    localparam int NLANES = WIDTH / LANE;

    // Operation encodings for the mode input.
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_SAR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    logic [WIDTH-1:0] q_r;
    logic             sout_r;
    logic [WIDTH-1:0] q_next_s;
    logic             sout_next_s;

    // Next-state selection: en low always holds, otherwise decode the op.
    always_comb begin
        q_next_s    = q_r;
        sout_next_s = sout_r;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_next_s    = q_r;
                    sout_next_s = sout_r;
                end
                MODE_LOAD: begin
                    // Each lane either takes its slice of d or keeps its value.
                    for (int i = 0; i < NLANES; i++) begin
                        if (be[i]) begin
                            q_next_s[i*LANE +: LANE] = d[i*LANE +: LANE];
                        end else begin
                            q_next_s[i*LANE +: LANE] = q_r[i*LANE +: LANE];
                        end
                    end
                    sout_next_s = sout_r;
                end
                MODE_SHL: begin
                    q_next_s    = {q_r[WIDTH-2:0], sin};
                    sout_next_s = q_r[WIDTH-1];
                end
                MODE_SHR: begin
                    q_next_s    = {sin, q_r[WIDTH-1:1]};
                    sout_next_s = q_r[0];
                end
                MODE_SAR: begin
                    q_next_s    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                    sout_next_s = q_r[0];
                end
                MODE_ROL: begin
                    q_next_s    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    sout_next_s = q_r[WIDTH-1];
                end
                MODE_ROR: begin
                    q_next_s    = {q_r[0], q_r[WIDTH-1:1]};
                    sout_next_s = q_r[0];
                end
                MODE_CLR: begin
                    q_next_s    = RESET_VAL;
                    sout_next_s = 1'b0;
                end
                default: begin
                    q_next_s    = q_r;
                    sout_next_s = sout_r;
                end
            endcase
        end else begin
            q_next_s    = q_r;
            sout_next_s = sout_r;
        end
    end

    // State register with asynchronous active-low reset to RESET_VAL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r    <= RESET_VAL;
            sout_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            sout_r <= sout_next_s;
        end
    end

    assign q    = q_r;
    assign sout = sout_r;
    assign zero = (q_r == {WIDTH{1'b0}});

endmodule
